// File: rtl/mp_pkg.sv
// Shared types and defaults for the multiprocessor memory subsystem.
package mp_pkg;

    localparam int unsigned NCORES = 2;
    localparam int unsigned WORD   = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last+1, wraps, and returns a
// one-hot winner, its index, and whether any request was found.
module rr_pick
    import mp_pkg::*;
#(
    parameter  int unsigned N  = NCORES,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt_c,
    output logic [IW-1:0] o_idx_c,
    output logic          o_valid_c
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_gnt_c   = '0;
        o_idx_c   = i_last;
        o_valid_c = 1'b0;
        w_cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = IW'((32'(i_last) + k) % N);
            if (!o_valid_c && i_req[w_cand]) begin
                o_valid_c       = 1'b1;
                o_idx_c         = w_cand;
                o_gnt_c[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between N cores.
// One access per GRANT cycle; outputs are muxed from the registered winner.
module mem_arbiter
    import mp_pkg::*;
#(
    parameter int unsigned N  = NCORES,
    parameter int unsigned AW = WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    we,
    input  logic [N*AW-1:0] adr,
    input  logic [N*AW-1:0] wd,
    output logic [AW-1:0]   rd,
    output logic [N-1:0]    ready,
    output logic [N-1:0]    gnt,
    output logic            mem_we,
    output logic [AW-1:0]   mem_adr,
    output logic [AW-1:0]   mem_wd,
    input  logic [AW-1:0]   mem_rd
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  w_gnt_nxt;
    logic [N-1:0]  w_pick_gnt;
    logic [IW-1:0] r_last;
    logic [IW-1:0] w_last_nxt;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_valid;
    logic [AW-1:0] w_adr [N];
    logic [AW-1:0] w_wd  [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign w_adr[gi] = adr[gi*AW +: AW];
        assign w_wd[gi]  = wd[gi*AW +: AW];
    end

    rr_pick #(.N(N)) u_rr_pick (
        .i_req     (req),
        .i_last    (r_last),
        .o_gnt_c   (w_pick_gnt),
        .o_idx_c   (w_pick_idx),
        .o_valid_c (w_pick_valid)
    );

    // last resets to N-1 so requester 0 is first in line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= IW'(N - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // r_last holds the current winner while in GRANT; a dropped req makes the cycle a no-op
    always_comb begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_last_nxt  = r_last;
        rd          = '0;
        ready       = '0;
        mem_we      = 1'b0;
        mem_adr     = '0;
        mem_wd      = '0;

        if (w_pick_valid) begin
            w_state_nxt = GRANT;
            w_gnt_nxt   = w_pick_gnt;
            w_last_nxt  = w_pick_idx;
        end

        if (r_state == GRANT) begin
            mem_adr       = w_adr[r_last];
            mem_wd        = w_wd[r_last];
            mem_we        = we[r_last] & req[r_last];
            ready[r_last] = req[r_last];
            rd            = mem_rd;
        end
    end

    assign gnt = r_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (N=4) with a shared RAM and a cycle-level
// reference model of grant order, completions and memory contents.
module tb_mem_arbiter;

    localparam int unsigned NC  = 4;
    localparam int unsigned AWB = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     req;
    logic [NC-1:0]     we;
    logic [NC*AWB-1:0] adr;
    logic [NC*AWB-1:0] wd;
    logic [AWB-1:0]    rd;
    logic [NC-1:0]     ready;
    logic [NC-1:0]     gnt;
    logic              mem_we;
    logic [AWB-1:0]    mem_adr;
    logic [AWB-1:0]    mem_wd;
    logic [AWB-1:0]    mem_rd;

    int   n_total = 0;
    int   n_bad   = 0;
    logic run     = 1'b0;

    logic [31:0] ram   [64];
    logic [31:0] m_ram [64];
    bit          m_busy;
    int          m_win;
    int          m_last;
    int          wait_cnt [NC];
    logic [3:0]  t_rq [10];
    logic [3:0]  t_ex [10];

    always #5 clk = ~clk;

    mem_arbiter #(.N(NC), .AW(AWB)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .adr     (adr),
        .wd      (wd),
        .rd      (rd),
        .ready   (ready),
        .gnt     (gnt),
        .mem_we  (mem_we),
        .mem_adr (mem_adr),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
    );

    assign mem_rd = ram[mem_adr[7:2]];

    function automatic logic [31:0] core_adr(input int i);
        return adr[i*32 +: 32];
    endfunction

    function automatic logic [31:0] core_wd(input int i);
        return wd[i*32 +: 32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_core(input int i, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
        req[i]          = r;
        we[i]           = w;
        adr[i*32 +: 32] = a;
        wd[i*32 +: 32]  = d;
    endtask

    task automatic idle(input int n);
        req = '0;
        we  = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        req   = '0;
        we    = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_table(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            req = t_rq[k];
            @(negedge clk);
            chk($sformatf("%s_%0d", tag, k), 32'(ready), 32'(t_ex[k]));
            @(posedge clk);
            #1;
        end
    endtask

    // Memory device: combinational read, write at the clock edge
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'hA5000000 + 32'(i) * 32'h00010101;
        forever begin
            @(posedge clk);
            if (mem_we === 1'b1) ram[mem_adr[7:2]] <= mem_wd;
        end
    end

    // Reference model: who owns the memory this cycle, and what memory must hold
    initial begin
        int          nxt;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) m_ram[i] = 32'hA5000000 + 32'(i) * 32'h00010101;
        m_busy = 1'b0;
        m_win  = 0;
        m_last = NC - 1;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_busy = 1'b0;
                m_last = NC - 1;
            end else begin
                if (m_busy && req[m_win] && we[m_win]) begin
                    a = core_adr(m_win);
                    m_ram[a[7:2]] = core_wd(m_win);
                end
                nxt = -1;
                for (int k = 1; k <= NC; k++)
                    if (nxt < 0 && req[(m_last + k) % NC]) nxt = (m_last + k) % NC;
                m_busy = (nxt >= 0);
                if (m_busy) begin
                    m_win  = nxt;
                    m_last = nxt;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [NC-1:0] e_gnt;
        logic [NC-1:0] e_ready;
        logic          e_we;
        logic [31:0]   e_adr;
        logic [31:0]   e_wd;
        logic [31:0]   e_rd;
        if (run) begin
            e_gnt   = '0;
            e_ready = '0;
            e_we    = 1'b0;
            e_adr   = '0;
            e_wd    = '0;
            e_rd    = '0;
            if (m_busy) begin
                e_gnt[m_win]   = 1'b1;
                e_ready[m_win] = req[m_win];
                e_we           = req[m_win] & we[m_win];
                e_adr          = core_adr(m_win);
                e_wd           = core_wd(m_win);
                e_rd           = m_ram[e_adr[7:2]];
            end
            chk("m_gnt",     32'(gnt),    32'(e_gnt));
            chk("m_ready",   32'(ready),  32'(e_ready));
            chk("m_mem_we",  32'(mem_we), 32'(e_we));
            chk("m_mem_adr", mem_adr,     e_adr);
            chk("m_mem_wd",  mem_wd,      e_wd);
            chk("m_rd",      rd,          e_rd);
            for (int i = 0; i < NC; i++) begin
                if (ready[i] === 1'b1) chk("wait_bound", 32'(wait_cnt[i] <= NC + 1), 32'd1);
                if (reset || req[i] !== 1'b1 || ready[i] === 1'b1) wait_cnt[i] = 0;
                else wait_cnt[i]++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        req   = '0;
        we    = '0;
        adr   = '0;
        wd    = '0;
        #1;
        reset = 1'b1;
        run   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_gnt",   32'(gnt),    32'h0);
            chk("idle_ready", 32'(ready),  32'h0);
            chk("idle_we",    32'(mem_we), 32'h0);
            chk("idle_adr",   mem_adr,     32'h0);
            chk("idle_rd",    rd,          32'h0);
            @(posedge clk);
            #1;
        end

        // Single read from core 0
        set_core(0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("t1_wait_ready", 32'(ready), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_ready", 32'(ready), 32'h1);
        chk("t1_adr",   mem_adr,    32'h10);
        chk("t1_rd",    rd,         32'hA5040404);
        @(posedge clk);
        #1;
        idle(3);

        // Two cores alternating with no bubbles
        do_reset();
        set_core(0, 1'b0, 1'b0, 32'h40, 32'h0);
        set_core(1, 1'b0, 1'b0, 32'h44, 32'h0);
        t_rq = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        t_ex = '{4'h0, 4'h1, 4'h2, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        run_table("rr2", 5);
        idle(3);

        // Four cores, then core 1 withdraws
        do_reset();
        for (int i = 0; i < NC; i++) set_core(i, 1'b0, 1'b0, 32'h40 + 32'(i) * 32'h4, 32'h0);
        t_rq = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD};
        t_ex = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h4, 4'h8, 4'h1, 4'h4};
        run_table("rr4", 10);
        idle(3);

        // Write by core 0 then read of the same word by core 1
        do_reset();
        set_core(0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
        set_core(1, 1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        chk("wr_wait_ready", 32'(ready), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wr_we",    32'(mem_we), 32'h1);
        chk("wr_adr",   mem_adr,     32'h20);
        chk("wr_wd",    mem_wd,      32'hDEADBEEF);
        chk("wr_ready", 32'(ready),  32'h1);
        @(posedge clk);
        #1;
        set_core(0, 1'b0, 1'b0, 32'h20, 32'hDEADBEEF);
        @(negedge clk);
        chk("raw_ready", 32'(ready), 32'h2);
        chk("raw_rd",    rd,         32'hDEADBEEF);
        @(posedge clk);
        #1;
        idle(3);

        // Granted core drops req: no-op cycle, rotation still advances
        do_reset();
        set_core(2, 1'b1, 1'b1, 32'h50, 32'h12345678);
        set_core(3, 1'b1, 1'b0, 32'h54, 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        set_core(2, 1'b0, 1'b1, 32'h50, 32'h12345678);
        set_core(0, 1'b1, 1'b0, 32'h58, 32'h0);
        @(negedge clk);
        chk("drop_gnt",   32'(gnt),    32'h4);
        chk("drop_we",    32'(mem_we), 32'h0);
        chk("drop_ready", 32'(ready),  32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drop_next", 32'(ready), 32'h8);
        @(posedge clk);
        #1;
        req[3] = 1'b0;
        @(negedge clk);
        chk("drop_after", 32'(ready), 32'h1);
        @(posedge clk);
        #1;
        idle(3);
        chk("drop_ram", ram[20], 32'hA5141414);

        // Reset in the middle of a granted write
        do_reset();
        set_core(0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
        set_core(1, 1'b1, 1'b0, 32'h34, 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        #1;
        chk("rst_pre_we", 32'(mem_we), 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_abort_we",  32'(mem_we), 32'h0);
        chk("rst_abort_gnt", 32'(gnt),    32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ram",        ram[12],    32'hA50C0C0C);
        chk("rst_idle_ready", 32'(ready), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_first",    32'(ready),  32'h1);
        chk("rst_first_we", 32'(mem_we), 32'h1);
        @(posedge clk);
        #1;
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
